// File: rtl/ex_pipe_reg_gen.sv
// ex_pipe_reg_gen: EX->MEM pipeline register with a valid/ready handshake.
// A main entry drives out_* and a skid entry absorbs the one extra beat that
// can arrive after back-pressure, which lets in_ready be a plain flop.
// Exception requests are prioritised (index 0 wins) and, when any fires,
// the result fields are killed and the exception code is overridden.
// Optional build macro: EX_PIPE_PERF_CNT_EN adds saturating stall/flush/exc
// performance counters (stall_cnt, flush_cnt, exc_cnt).
module ex_pipe_reg_gen #(
  parameter int ADDR_W   = 30,
  parameter int DATA_W   = 32,
  parameter int DST_W    = 5,
  parameter int MEMOP_W  = 2,
  parameter int CTRLOP_W = 2,
  parameter int EXC_W    = 3,
  parameter int NUM_EXC  = 2
`ifdef EX_PIPE_PERF_CNT_EN
  ,
  parameter int CNT_W    = 16
`endif
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [ADDR_W-1:0]        in_pc,
  input  logic                     in_en,
  input  logic                     in_br_flag,
  input  logic [EXC_W-1:0]         in_exp_code,
  input  logic [MEMOP_W-1:0]       in_mem_op,
  input  logic [DATA_W-1:0]        in_mem_wr_data,
  input  logic [CTRLOP_W-1:0]      in_ctrl_op,
  input  logic [DST_W-1:0]         in_dst_addr,
  input  logic                     in_gpr_we_,
  input  logic [DATA_W-1:0]        in_alu_data,
  input  logic [NUM_EXC-1:0]       exc_req,
  input  logic [NUM_EXC*EXC_W-1:0] exc_code,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [ADDR_W-1:0]        out_pc,
  output logic                     out_en,
  output logic                     out_br_flag,
  output logic [EXC_W-1:0]         out_exp_code,
  output logic [MEMOP_W-1:0]       out_mem_op,
  output logic [DATA_W-1:0]        out_mem_wr_data,
  output logic [CTRLOP_W-1:0]      out_ctrl_op,
  output logic [DST_W-1:0]         out_dst_addr,
  output logic                     out_gpr_we_,
  output logic [DATA_W-1:0]        out_data
`ifdef EX_PIPE_PERF_CNT_EN
  ,
  output logic [CNT_W-1:0]         stall_cnt,
  output logic [CNT_W-1:0]         flush_cnt,
  output logic [CNT_W-1:0]         exc_cnt
`endif
);

  typedef struct packed {
    logic [ADDR_W-1:0]   pc;
    logic                en;
    logic                br_flag;
    logic [EXC_W-1:0]    exp_code;
    logic [MEMOP_W-1:0]  mem_op;
    logic [DATA_W-1:0]   mem_wr_data;
    logic [CTRLOP_W-1:0] ctrl_op;
    logic [DST_W-1:0]    dst_addr;
    logic                gpr_we_;
    logic [DATA_W-1:0]   data;
  } entry_t;

  entry_t r_main, r_main_next;
  entry_t r_skid, r_skid_next;
  logic   r_main_valid, r_main_valid_next;
  logic   r_skid_valid, r_skid_valid_next;
  logic   r_in_ready, r_in_ready_next;

  entry_t           w_new_entry;
  entry_t           w_rst_entry;
  logic             w_exc_any;
  logic [EXC_W-1:0] w_sel_code;
  logic             w_push;
  logic             w_pop;

  assign w_push = in_valid & r_in_ready;
  assign w_pop  = r_main_valid & out_ready;

  // Idle/flushed contents: everything zero except the active-low write enable.
  always_comb begin
    w_rst_entry         = '0;
    w_rst_entry.gpr_we_ = 1'b1;
  end

  // Priority select: scan high to low so the lowest set index wins.
  always_comb begin
    w_exc_any  = |exc_req;
    w_sel_code = '0;
    for (int i = NUM_EXC - 1; i >= 0; i--) begin
      if (exc_req[i]) begin
        w_sel_code = exc_code[i*EXC_W +: EXC_W];
      end
    end
  end

  // Entry formation: an exception keeps pc/en/br_flag and kills the rest.
  always_comb begin
    w_new_entry.pc          = in_pc;
    w_new_entry.en          = in_en;
    w_new_entry.br_flag     = in_br_flag;
    w_new_entry.exp_code    = in_exp_code;
    w_new_entry.mem_op      = in_mem_op;
    w_new_entry.mem_wr_data = in_mem_wr_data;
    w_new_entry.ctrl_op     = in_ctrl_op;
    w_new_entry.dst_addr    = in_dst_addr;
    w_new_entry.gpr_we_     = in_gpr_we_;
    w_new_entry.data        = in_alu_data;
    if (w_exc_any) begin
      w_new_entry.exp_code    = w_sel_code;
      w_new_entry.mem_op      = '0;
      w_new_entry.mem_wr_data = '0;
      w_new_entry.ctrl_op     = '0;
      w_new_entry.dst_addr    = '0;
      w_new_entry.gpr_we_     = 1'b1;
      w_new_entry.data        = '0;
    end
  end

  // Main/skid next-state; a push only reaches skid when skid is known empty
  // because in_ready mirrors the skid being free.
  always_comb begin
    r_main_next       = r_main;
    r_main_valid_next = r_main_valid;
    r_skid_next       = r_skid;
    r_skid_valid_next = r_skid_valid;
    if (flush) begin
      r_main_next       = w_rst_entry;
      r_main_valid_next = 1'b0;
      r_skid_valid_next = 1'b0;
    end else if (w_pop) begin
      if (r_skid_valid) begin
        r_main_next       = r_skid;
        r_main_valid_next = 1'b1;
        if (w_push) begin
          r_skid_next = w_new_entry;
        end else begin
          r_skid_valid_next = 1'b0;
        end
      end else begin
        if (w_push) begin
          r_main_next = w_new_entry;
        end
        r_main_valid_next = w_push;
      end
    end else if (!r_main_valid) begin
      if (w_push) begin
        r_main_next       = w_new_entry;
        r_main_valid_next = 1'b1;
      end
    end else if (w_push) begin
      r_skid_next       = w_new_entry;
      r_skid_valid_next = 1'b1;
    end
    r_in_ready_next = ~r_skid_valid_next;
  end

  // State registers; reset behaves exactly like a flush.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_main       <= w_rst_entry;
      r_main_valid <= 1'b0;
      r_skid       <= w_rst_entry;
      r_skid_valid <= 1'b0;
      r_in_ready   <= 1'b1;
    end else begin
      r_main       <= r_main_next;
      r_main_valid <= r_main_valid_next;
      r_skid       <= r_skid_next;
      r_skid_valid <= r_skid_valid_next;
      r_in_ready   <= r_in_ready_next;
    end
  end

  assign in_ready        = r_in_ready;
  assign out_valid       = r_main_valid;
  assign out_pc          = r_main.pc;
  assign out_en          = r_main.en;
  assign out_br_flag     = r_main.br_flag;
  assign out_exp_code    = r_main.exp_code;
  assign out_mem_op      = r_main.mem_op;
  assign out_mem_wr_data = r_main.mem_wr_data;
  assign out_ctrl_op     = r_main.ctrl_op;
  assign out_dst_addr    = r_main.dst_addr;
  assign out_gpr_we_     = r_main.gpr_we_;
  assign out_data        = r_main.data;

`ifdef EX_PIPE_PERF_CNT_EN
  logic [CNT_W-1:0] r_stall_cnt;
  logic [CNT_W-1:0] r_flush_cnt;
  logic [CNT_W-1:0] r_exc_cnt;

  // Saturating event counters; an exception push only counts if accepted.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
      r_exc_cnt   <= '0;
    end else begin
      if (r_main_valid && !out_ready && (r_stall_cnt != '1)) begin
        r_stall_cnt <= r_stall_cnt + 1'b1;
      end
      if (flush && (r_main_valid || r_skid_valid) && (r_flush_cnt != '1)) begin
        r_flush_cnt <= r_flush_cnt + 1'b1;
      end
      if (!flush && w_push && w_exc_any && (r_exc_cnt != '1)) begin
        r_exc_cnt <= r_exc_cnt + 1'b1;
      end
    end
  end

  assign stall_cnt = r_stall_cnt;
  assign flush_cnt = r_flush_cnt;
  assign exc_cnt   = r_exc_cnt;
`endif

endmodule

// File: tb/tb_ex_pipe_reg_gen.sv
// Scoreboard bench for ex_pipe_reg_gen: the driver pushes expected entries
// when a beat is accepted, the monitor pops and compares on each handshake.
module tb_ex_pipe_reg_gen;

  typedef struct packed {
    logic [29:0] pc;
    logic        en;
    logic        br_flag;
    logic [2:0]  exp_code;
    logic [1:0]  mem_op;
    logic [31:0] mem_wr_data;
    logic [1:0]  ctrl_op;
    logic [4:0]  dst_addr;
    logic        gpr_we_;
    logic [31:0] data;
  } ent_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [29:0] in_pc = '0;
  logic        in_en = 1'b0;
  logic        in_br_flag = 1'b0;
  logic [2:0]  in_exp_code = '0;
  logic [1:0]  in_mem_op = '0;
  logic [31:0] in_mem_wr_data = '0;
  logic [1:0]  in_ctrl_op = '0;
  logic [4:0]  in_dst_addr = '0;
  logic        in_gpr_we_ = 1'b1;
  logic [31:0] in_alu_data = '0;
  logic [1:0]  exc_req = '0;
  logic [5:0]  exc_code = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [29:0] out_pc;
  logic        out_en;
  logic        out_br_flag;
  logic [2:0]  out_exp_code;
  logic [1:0]  out_mem_op;
  logic [31:0] out_mem_wr_data;
  logic [1:0]  out_ctrl_op;
  logic [4:0]  out_dst_addr;
  logic        out_gpr_we_;
  logic [31:0] out_data;
`ifdef EX_PIPE_PERF_CNT_EN
  logic [15:0] stall_cnt;
  logic [15:0] flush_cnt;
  logic [15:0] exc_cnt;
`endif

  ex_pipe_reg_gen dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_pc(in_pc), .in_en(in_en), .in_br_flag(in_br_flag),
    .in_exp_code(in_exp_code), .in_mem_op(in_mem_op),
    .in_mem_wr_data(in_mem_wr_data), .in_ctrl_op(in_ctrl_op),
    .in_dst_addr(in_dst_addr), .in_gpr_we_(in_gpr_we_),
    .in_alu_data(in_alu_data), .exc_req(exc_req), .exc_code(exc_code),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_pc(out_pc), .out_en(out_en), .out_br_flag(out_br_flag),
    .out_exp_code(out_exp_code), .out_mem_op(out_mem_op),
    .out_mem_wr_data(out_mem_wr_data), .out_ctrl_op(out_ctrl_op),
    .out_dst_addr(out_dst_addr), .out_gpr_we_(out_gpr_we_),
    .out_data(out_data)
`ifdef EX_PIPE_PERF_CNT_EN
    , .stall_cnt(stall_cnt), .flush_cnt(flush_cnt), .exc_cnt(exc_cnt)
`endif
  );

  always #5 clk = ~clk;

  ent_t exp_q[$];
  int   n_checks = 0;
  int   n_pass = 0;

  function automatic ent_t dut_out();
    ent_t e;
    e = '{out_pc, out_en, out_br_flag, out_exp_code, out_mem_op,
          out_mem_wr_data, out_ctrl_op, out_dst_addr, out_gpr_we_, out_data};
    return e;
  endfunction

  // Reference entry: side fields are derived from the data word so every
  // beat exercises distinct values.
  function automatic ent_t model(input logic [29:0] pc, input logic [31:0] d,
                                 input logic [1:0] req, input logic [5:0] codes);
    ent_t e;
    e.pc          = pc;
    e.en          = d[0];
    e.br_flag     = d[1];
    if (req == 2'b00) begin
      e.exp_code    = d[4:2];
      e.mem_op      = d[6:5];
      e.mem_wr_data = ~d;
      e.ctrl_op     = d[8:7];
      e.dst_addr    = d[13:9];
      e.gpr_we_     = d[14];
      e.data        = d;
    end else begin
      e.exp_code    = req[0] ? codes[2:0] : codes[5:3];
      e.mem_op      = '0;
      e.mem_wr_data = '0;
      e.ctrl_op     = '0;
      e.dst_addr    = '0;
      e.gpr_we_     = 1'b1;
      e.data        = '0;
    end
    return e;
  endfunction

  task automatic chk(input string name, input logic [127:0] got, input logic [127:0] want);
    n_checks++;
    if (got === want) begin
      n_pass++;
      $display("check %s ok: %0h", name, got);
    end else begin
      $display("FAIL %s: got %0h expected %0h", name, got, want);
    end
  endtask

  task automatic drive_fields(input logic [29:0] pc, input logic [31:0] d,
                              input logic [1:0] req, input logic [5:0] codes);
    in_pc = pc; in_en = d[0]; in_br_flag = d[1]; in_exp_code = d[4:2];
    in_mem_op = d[6:5]; in_mem_wr_data = ~d; in_ctrl_op = d[8:7];
    in_dst_addr = d[13:9]; in_gpr_we_ = d[14]; in_alu_data = d;
    exc_req = req; exc_code = codes;
  endtask

  // One-cycle beat; acc reports whether the DUT accepted it.
  task automatic send(input logic [29:0] pc, input logic [31:0] d,
                      input logic [1:0] req, input logic [5:0] codes, output bit acc);
    drive_fields(pc, d, req, codes);
    in_valid = 1'b1;
    @(negedge clk);
    acc = in_ready;
    if (acc) exp_q.push_back(model(pc, d, req, codes));
    $display("push pc=%0h data=%0h req=%b accepted=%0d", pc, d, req, acc);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    exp_q.delete();
    idle(2);
    rst = 1'b0;
  endtask

  // Monitor: every handshake pops and compares one expected entry.
  always @(negedge clk) begin
    if (!rst && !flush && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        $display("FAIL pop_unexpected: got %0h expected no entry", dut_out());
      end else begin
        chk("pop", 128'(dut_out()), 128'(exp_q.pop_front()));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end

  ent_t rst_ent;
  bit   acc;

  initial begin
    rst_ent = '0;
    rst_ent.gpr_we_ = 1'b1;
    do_reset();

    // Reset then idle.
    idle(2);
    @(negedge clk);
    chk("rst_out_valid", 128'(out_valid), 128'(0));
    chk("rst_in_ready", 128'(in_ready), 128'(1));
    chk("rst_fields", 128'(dut_out()), 128'(rst_ent));
    @(posedge clk); #1;

    // Stream four entries with no bubbles; each appears one cycle later.
    out_ready = 1'b1;
    send(30'h100, 32'h0000_1234, 2'b00, 6'd0, acc);
    chk("stream_lat_valid0", 128'(out_valid), 128'(1));
    chk("stream_lat_data0", 128'(out_data), 128'h1234);
    send(30'h101, 32'hDEAD_BEEF, 2'b00, 6'd0, acc);
    chk("stream_lat_data1", 128'(out_data), 128'hDEAD_BEEF);
    send(30'h102, 32'h0000_4AAA, 2'b00, 6'd0, acc);
    chk("stream_acc2", 128'(acc), 128'(1));
    send(30'h103, 32'h8765_5555, 2'b00, 6'd0, acc);
    chk("stream_lat_data3", 128'(out_data), 128'h8765_5555);
    idle(2);

    // Back-pressure: A in main, B in skid, C refused then re-presented.
    out_ready = 1'b0;
    send(30'h200, 32'h0000_00A1, 2'b00, 6'd0, acc);
    chk("bp_acc_a", 128'(acc), 128'(1));
    send(30'h201, 32'h0000_00B2, 2'b00, 6'd0, acc);
    chk("bp_acc_b", 128'(acc), 128'(1));
    chk("bp_in_ready_full", 128'(in_ready), 128'(0));
    send(30'h202, 32'h0000_00C3, 2'b00, 6'd0, acc);
    chk("bp_acc_c_refused", 128'(acc), 128'(0));
    chk("bp_head_hold", 128'(out_data), 128'h00A1);
    out_ready = 1'b1;
    idle(1);
    chk("bp_in_ready_back", 128'(in_ready), 128'(1));
    send(30'h202, 32'h0000_00C3, 2'b00, 6'd0, acc);
    chk("bp_acc_c", 128'(acc), 128'(1));
    idle(3);

    // Exceptions: both requests set -> source 0 code (1) wins.
    send(30'h300, 32'h0000_0021, 2'b11, {3'd2, 3'd1}, acc);
    chk("exc_code_prio", 128'(out_exp_code), 128'(1));
    chk("exc_mem_op", 128'(out_mem_op), 128'(0));
    chk("exc_gpr_we", 128'(out_gpr_we_), 128'(1));
    chk("exc_data", 128'(out_data), 128'(0));
    chk("exc_pc", 128'(out_pc), 128'h300);
    send(30'h301, 32'h0000_7FFF, 2'b10, {3'd2, 3'd1}, acc);
    chk("exc_code_src1", 128'(out_exp_code), 128'(2));
    idle(2);

    // Flush with both entries full and a simultaneous push.
    out_ready = 1'b0;
    send(30'h400, 32'h0000_0401, 2'b00, 6'd0, acc);
    send(30'h401, 32'h0000_0402, 2'b00, 6'd0, acc);
    drive_fields(30'h402, 32'h0000_0403, 2'b00, 6'd0);
    in_valid = 1'b1;
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    in_valid = 1'b0;
    exp_q.delete();
    chk("flush_out_valid", 128'(out_valid), 128'(0));
    chk("flush_in_ready", 128'(in_ready), 128'(1));
    chk("flush_fields", 128'(dut_out()), 128'(rst_ent));
`ifdef EX_PIPE_PERF_CNT_EN
    chk("flush_cnt", 128'(flush_cnt), 128'(1));
`endif
    out_ready = 1'b1;
    idle(4);

`ifdef EX_PIPE_PERF_CNT_EN
    // Five stall cycles on a valid head.
    do_reset();
    out_ready = 1'b0;
    send(30'h500, 32'h0000_0501, 2'b00, 6'd0, acc);
    idle(5);
    chk("stall_cnt", 128'(stall_cnt), 128'(5));
    out_ready = 1'b1;
    idle(2);
`endif

    chk("scoreboard_empty", 128'(exp_q.size()), 128'(0));
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
